// File: rtl/load_store_unit_pkg.sv
// Shared processor definitions used by the load/store unit: the LSU state
// encoding, the register-file geometry, and a helper that decides whether a
// destination pointer names a writable general register.
package load_store_unit_pkg;

  // Load/store unit sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STORE = 2'd1,
    LOAD  = 2'd2,
    WB    = 2'd3
  } lsu_state_e;

  // Register file: eight general registers (index 0 is the hard-wired zero
  // register) plus an overflow slot at index 8 that loads must never write.
  localparam int NUM_REGS = 9;
  localparam int OVF_IDX  = NUM_REGS - 1;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int RD_W   = 5;

  // True when a load result may be written to register rd: never the zero
  // register, never the overflow slot or anything beyond it.
  function automatic logic rd_writable(input logic [RD_W-1:0] rd);
    return (rd != '0) && (rd < RD_W'(OVF_IDX));
  endfunction

endpackage : load_store_unit_pkg

// File: rtl/lsu_timer.sv
// Wait-cycle counter for the load/store unit. It is cleared when a memory
// access begins and advances once for every strobe cycle that ends without an
// acknowledge. 'expired' flags the cycle whose increment reaches TIMEOUT, so a
// strobe that is never acknowledged stays up for exactly TIMEOUT cycles.
module lsu_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] MAX  = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Counter register; reset and clear both return it to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Next count: clear wins, otherwise step while enabled, saturating at TIMEOUT.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  // This cycle's missing acknowledge is the one that reaches TIMEOUT.
  always_comb begin
    expired = enable && (count_q == LAST);
  end

endmodule : lsu_timer

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between the core and data memory.
//
// Handshake: the core's request transfers on a cycle where req_valid and
// req_ready are both high (req_ready is high only in IDLE); requests offered
// while busy are not queued. Toward memory, mem_we/mem_re are held until the
// cycle in which mem_ack is high; that cycle completes the access. If no
// acknowledge arrives within TIMEOUT strobe cycles the access is abandoned,
// the sticky err flag is set and no register write happens. Loads finish with
// one WB cycle that writes the register file unless rd is the zero register
// or outside the eight general registers.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_load,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [RD_W-1:0]   req_rd,
  input  logic [DATA_W-1:0] store_value,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              rf_we,
  output logic [RD_W-1:0]   rf_ptr_w,
  output logic [DATA_W-1:0] rf_di,
  output logic              busy,
  output logic              err,
  output lsu_state_e        dbg_state
);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic              err_q, err_d;

  logic accept;
  logic strobe;
  logic timer_clear;
  logic timer_en;
  logic timer_expired;

  assign accept      = req_valid && (state_q == IDLE);
  assign strobe      = (state_q == STORE) || (state_q == LOAD);
  // Starting a new access restarts the wait count.
  assign timer_clear = accept;
  // Only strobe cycles left unacknowledged count toward the timeout.
  assign timer_en    = strobe && !mem_ack;

  lsu_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (timer_expired)
  );

  // State and captured request/response registers; reset aborts any access.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
    end
  end

  // Next-state and register-capture logic.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    rd_d    = rd_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = store_value;
          rd_d    = req_rd;
          err_d   = 1'b0;
          state_d = req_is_load ? LOAD : STORE;
        end
      end
      STORE: begin
        if (mem_ack) begin
          state_d = IDLE;
        end else if (timer_expired) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (mem_ack) begin
          rdata_d = mem_rdata;
          state_d = WB;
        end else if (timer_expired) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      WB: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from the current state; data ports show the held registers.
  always_comb begin
    req_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
    mem_we    = (state_q == STORE);
    mem_re    = (state_q == LOAD);
    rf_we     = (state_q == WB) && rd_writable(rd_q);
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    rf_ptr_w  = rd_q;
    rf_di     = rdata_q;
    err       = err_q;
    dbg_state = state_q;
  end

endmodule : load_store_unit

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a memory responder with programmable
// acknowledge delay, driver tasks for requests, and a monitor that pops an
// expected queue for every completed memory access and register-file write.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  localparam int TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_is_load = 1'b0;
  logic [7:0] req_addr = '0;
  logic [4:0] req_rd = '0;
  logic [7:0] store_value = '0;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic       mem_re;
  logic [7:0] mem_rdata = '0;
  logic       mem_ack = 1'b0;
  logic       rf_we;
  logic [4:0] rf_ptr_w;
  logic [7:0] rf_di;
  logic       busy;
  logic       err;
  lsu_state_e dbg_state;

  // Scoreboard queues: {we, re, addr, wdata} per access, {ptr, data} per write.
  logic [17:0] mem_q[$];
  logic [12:0] rf_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int we_cycles, re_cycles, rf_cycles, busy_cycles, wb_cycles, rf_cyc;

  // Responder configuration.
  int         ack_delay = 0;
  bit         ack_en    = 1'b1;
  bit         force_ack = 1'b0;
  logic [7:0] rdata_cfg = '0;
  int         wait_cnt  = 0;

  load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_is_load (req_is_load),
    .req_addr    (req_addr),
    .req_rd      (req_rd),
    .store_value (store_value),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .mem_re      (mem_re),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .rf_we       (rf_we),
    .rf_ptr_w    (rf_ptr_w),
    .rf_di       (rf_di),
    .busy        (busy),
    .err         (err),
    .dbg_state   (dbg_state)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clr_counts();
    we_cycles   = 0;
    re_cycles   = 0;
    rf_cycles   = 0;
    busy_cycles = 0;
    wb_cycles   = 0;
    rf_cyc      = -1;
  endtask

  // Memory responder: acknowledges after ack_delay unacknowledged strobe cycles.
  always begin
    @(posedge clk);
    #1;
    if ((mem_we || mem_re) && ack_en) begin
      if (wait_cnt >= ack_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = rdata_cfg;
        wait_cnt  = 0;
      end else begin
        mem_ack  = 1'b0;
        wait_cnt = wait_cnt + 1;
      end
    end else begin
      mem_ack  = force_ack;
      wait_cnt = 0;
    end
  end

  // Monitor: counts activity and scores completed accesses and rf writes.
  always @(negedge clk) begin
    logic [17:0] mexp;
    logic [12:0] rexp;
    check("strobe_exclusive", 32'(mem_we & mem_re), 32'd0);
    if (mem_we) we_cycles++;
    if (mem_re) re_cycles++;
    if (busy) busy_cycles++;
    if (dbg_state == WB) wb_cycles++;
    if ((mem_we || mem_re) && mem_ack) begin
      check("mem_access_expected", 32'(mem_q.size() > 0), 32'd1);
      if (mem_q.size() > 0) begin
        mexp = mem_q.pop_front();
        check("mem_access", 32'({mem_we, mem_re, mem_addr, mem_wdata}), 32'(mexp));
      end
    end
    if (rf_we) begin
      rf_cycles++;
      rf_cyc = cyc;
      check("rf_write_expected", 32'(rf_q.size() > 0), 32'd1);
      if (rf_q.size() > 0) begin
        rexp = rf_q.pop_front();
        check("rf_write", 32'({rf_ptr_w, rf_di}), 32'(rexp));
      end
    end
  end

  // Present a request and hold it until accepted; returns at the cycle after accept.
  task automatic issue(input bit is_load, input logic [7:0] addr, input logic [4:0] rd,
                       input logic [7:0] val, output int acc_cyc);
    req_is_load = is_load;
    req_addr    = addr;
    req_rd      = rd;
    store_value = val;
    req_valid   = 1'b1;
    acc_cyc     = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req_ready) begin
        acc_cyc = cyc;
        break;
      end
    end
    check("accept_in_budget", 32'(acc_cyc >= 0), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int idle_cyc);
    idle_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin
        idle_cyc = cyc;
        break;
      end
    end
    check("idle_in_budget", 32'(idle_cyc >= 0), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc, acc1, idl, viol;

    // Reset values.
    clr_counts();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_re", 32'(mem_re), 32'd0);
    check("rst_rf_we", 32'(rf_we), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_rf_ptr_w", 32'(rf_ptr_w), 32'd0);
    check("rst_rf_di", 32'(rf_di), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Store 0x20 <- 0xA5, acknowledged in the third strobe cycle.
    ack_en = 1'b1; ack_delay = 2;
    mem_q.push_back({1'b1, 1'b0, 8'h20, 8'hA5});
    clr_counts();
    issue(1'b0, 8'h20, 5'd0, 8'hA5, acc);
    wait_idle(20, idl);
    check("store_we_cycles", 32'(we_cycles), 32'd3);
    check("store_no_rf", 32'(rf_cycles), 32'd0);
    check("store_hold_addr", 32'(mem_addr), 32'h20);
    check("store_hold_wdata", 32'(mem_wdata), 32'hA5);

    // Minimum-latency store.
    ack_delay = 0;
    mem_q.push_back({1'b1, 1'b0, 8'h21, 8'h3E});
    issue(1'b0, 8'h21, 5'd0, 8'h3E, acc);
    wait_idle(20, idl);
    check("store_min_latency", 32'(idl - acc), 32'd2);

    // Load 0x10 into r3, data 0x5C acknowledged immediately.
    rdata_cfg = 8'h5C;
    mem_q.push_back({1'b0, 1'b1, 8'h10, 8'h00});
    rf_q.push_back({5'd3, 8'h5C});
    clr_counts();
    issue(1'b1, 8'h10, 5'd3, 8'h00, acc);
    wait_idle(20, idl);
    check("load_rf_latency", 32'(rf_cyc - acc), 32'd2);
    check("load_rf_pulse", 32'(rf_cycles), 32'd1);
    check("load_re_cycles", 32'(re_cycles), 32'd1);

    // Loads to r0 and r8: WB happens, no register write.
    rdata_cfg = 8'hE1;
    mem_q.push_back({1'b0, 1'b1, 8'h70, 8'h00});
    clr_counts();
    issue(1'b1, 8'h70, 5'd0, 8'h00, acc);
    wait_idle(20, idl);
    check("rd0_wb_cycles", 32'(wb_cycles), 32'd1);
    check("rd0_busy_cycles", 32'(busy_cycles), 32'd2);
    check("rd0_no_rf", 32'(rf_cycles), 32'd0);
    mem_q.push_back({1'b0, 1'b1, 8'h71, 8'h00});
    clr_counts();
    issue(1'b1, 8'h71, 5'd8, 8'h00, acc);
    wait_idle(20, idl);
    check("rd8_wb_cycles", 32'(wb_cycles), 32'd1);
    check("rd8_no_rf", 32'(rf_cycles), 32'd0);
    check("rd8_hold_ptr", 32'(rf_ptr_w), 32'd8);
    check("rd8_hold_di", 32'(rf_di), 32'hE1);

    // Load never acknowledged: timeout after TIMEOUT strobe cycles.
    ack_en = 1'b0;
    clr_counts();
    issue(1'b1, 8'h33, 5'd5, 8'h00, acc);
    wait_idle(40, idl);
    check("timeout_re_cycles", 32'(re_cycles), 32'(TIMEOUT));
    check("timeout_err", 32'(err), 32'd1);
    check("timeout_no_rf", 32'(rf_cycles), 32'd0);
    check("timeout_idle_latency", 32'(idl - acc), 32'(TIMEOUT + 1));
    ack_en = 1'b1; ack_delay = 1;
    mem_q.push_back({1'b1, 1'b0, 8'h44, 8'h99});
    issue(1'b0, 8'h44, 5'd0, 8'h99, acc);
    @(negedge clk);
    check("accept_clears_err", 32'(err), 32'd0);
    wait_idle(20, idl);

    // Acknowledge while idle is ignored.
    force_ack = 1'b1;
    clr_counts();
    repeat (4) @(posedge clk);
    #1;
    force_ack = 1'b0;
    check("idle_ack_busy", 32'(busy_cycles), 32'd0);
    check("idle_ack_no_rf", 32'(rf_cycles), 32'd0);

    // Reset during a load in its acknowledge cycle.
    ack_delay = 0; rdata_cfg = 8'h77;
    mem_q.push_back({1'b0, 1'b1, 8'h5A, 8'h00});
    clr_counts();
    issue(1'b1, 8'h5A, 5'd4, 8'h00, acc);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_req_ready", 32'(req_ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_mem_re", 32'(mem_re), 32'd0);
    check("abort_rf_we", 32'(rf_we), 32'd0);
    check("abort_err", 32'(err), 32'd0);
    check("abort_mem_addr", 32'(mem_addr), 32'd0);
    check("abort_mem_wdata", 32'(mem_wdata), 32'd0);
    check("abort_rf_ptr_w", 32'(rf_ptr_w), 32'd0);
    check("abort_rf_di", 32'(rf_di), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_rf", 32'(rf_cycles), 32'd0);

    // req_valid held through a store: the next request waits for IDLE.
    ack_delay = 3; rdata_cfg = 8'h3C;
    mem_q.push_back({1'b1, 1'b0, 8'h50, 8'h11});
    mem_q.push_back({1'b0, 1'b1, 8'h60, 8'h22});
    rf_q.push_back({5'd2, 8'h3C});
    clr_counts();
    req_is_load = 1'b0; req_addr = 8'h50; req_rd = 5'd0; store_value = 8'h11;
    req_valid = 1'b1;
    @(negedge clk);
    check("held_first_ready", 32'(req_ready), 32'd1);
    acc1 = cyc;
    @(posedge clk);
    #1;
    req_is_load = 1'b1; req_addr = 8'h60; req_rd = 5'd2; store_value = 8'h22;
    viol = 0; idl = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) begin
        if (req_ready) viol++;
      end else begin
        idl = cyc;
        break;
      end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("held_ready_low_busy", 32'(viol), 32'd0);
    check("held_second_accept", 32'(idl - acc1), 32'd5);
    wait_idle(20, idl);
    check("held_we_cycles", 32'(we_cycles), 32'd4);
    check("held_re_cycles", 32'(re_cycles), 32'd4);
    check("held_rf_cycles", 32'(rf_cycles), 32'd1);

    // Drain and report.
    repeat (3) @(posedge clk);
    #1;
    check("mem_queue_drained", 32'(mem_q.size()), 32'd0);
    check("rf_queue_drained", 32'(rf_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_load_store_unit

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, max cycles to wait for mem_ack before abort.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  core presents a memory request.
REQ-005 SHALL have port req_ready  output  1  unit can accept a request this cycle.
REQ-006 SHALL have port req_is_load  input  1  1 = load, 0 = store.
REQ-007 SHALL have port req_addr  input  8  data-memory byte address.
REQ-008 SHALL have port req_rd  input  5  register-file destination pointer for loads.
REQ-009 SHALL have port store_value  input  8  register-file store data, sampled at accept.
REQ-010 SHALL have port mem_addr  output  8  address to data memory.
REQ-011 SHALL have port mem_wdata  output  8  store data to data memory.
REQ-012 SHALL have port mem_we  output  1  write strobe, held until ack.
REQ-013 SHALL have port mem_re  output  1  read strobe, held until ack.
REQ-014 SHALL have port mem_rdata  input  8  read data, valid in the mem_ack cycle.
REQ-015 SHALL have port mem_ack  input  1  memory completes current access.
REQ-016 SHALL have port rf_we  output  1  register-file write enable.
REQ-017 SHALL have port rf_ptr_w  output  5  register-file write pointer.
REQ-018 SHALL have port rf_di  output  8  register-file write data.
REQ-019 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-020 SHALL have port err  output  1  sticky timeout flag.

Function
REQ-021 SHALL implement states IDLE, STORE, LOAD, WB.
REQ-022 req_ready SHALL equal (state == IDLE); accept = req_valid & req_ready.
REQ-023 On accept, SHALL register req_addr, store_value, req_rd; go to LOAD if req_is_load else STORE; clear err.
REQ-024 STORE: mem_we=1, mem_addr/mem_wdata from registered values; on mem_ack -> IDLE next cycle.
REQ-025 LOAD: mem_re=1; on mem_ack capture mem_rdata -> WB.
REQ-026 WB: exactly one cycle rf_we=1, rf_ptr_w=captured rd, rf_di=captured data; -> IDLE.
REQ-027 rf_we SHALL be suppressed in WB when rd==0 (zero register) or rd>=8 (overflow/out-of-range); WB cycle still occurs.
REQ-028 mem_we and mem_re SHALL never be high together; both low outside STORE/LOAD.
REQ-029 Minimum latency: store accept-to-IDLE 2 cycles (ack in first strobe cycle); load accept-to-rf_we 2 cycles.
REQ-030 Wait counter SHALL clear on entering STORE/LOAD and increment each strobe cycle without ack.
REQ-031 If counter reaches TIMEOUT without ack, SHALL drop strobe, set err, go to IDLE; no rf write.
REQ-032 mem_ack in IDLE or WB SHALL be ignored.
REQ-033 req_valid while busy SHALL be ignored (not queued).
REQ-034 mem_addr, mem_wdata, rf_ptr_w, rf_di SHALL hold last registered values when not strobed.

Reset
REQ-035 reset SHALL force IDLE next edge, regardless of state, aborting any access without rf write.
REQ-036 After reset: req_ready=1, busy=0, mem_we=0, mem_re=0, rf_we=0, err=0, mem_addr=0, mem_wdata=0, rf_ptr_w=0, rf_di=0, counter=0.

Structure
REQ-037 State enum (IDLE, STORE, LOAD, WB) and register count constant (8 general + overflow at index 8) SHALL live in the shared processor package.
REQ-038 Timeout counter SHALL be one sub-module, lsu_timer (clear, enable, expired).
REQ-039 Single always_ff for state/data registers; outputs decoded combinationally from state.

Verification
REQ-040 Store addr 0x20 data 0xA5, ack 3 cycles after strobe -> mem_we high 3 cycles, mem_addr 0x20, mem_wdata 0xA5, no rf_we.
REQ-041 Load addr 0x10, rd 3, rdata 0x5C ack first cycle -> rf_we pulse 1 cycle, rf_ptr_w 3, rf_di 0x5C, 2 cycles after accept.
REQ-042 Load rd 0 and rd 8, ack given -> WB cycle occurs, rf_we stays 0 both times.
REQ-043 Load, never ack, TIMEOUT=15 -> mem_re drops after 15 cycles, err=1, IDLE; next accept clears err.
REQ-044 Reset asserted during LOAD with ack same cycle -> IDLE next cycle, no rf_we, all outputs at reset values.
REQ-045 req_valid held high during a store -> second request accepted only after return to IDLE; req_ready low throughout busy.
